memory_stage: RTL and testbench

- Pipeline stage directly upstream of writeback.
- Performs data-memory loads and stores using the effective address computed by execute, over a valid/ready request and valid response bus.
- Aligns and sign/zero-extends load data, then hands the result plus pass-through decode flags to writeback.
- Non-memory instructions pass through with result_data unchanged.

---
 rtl/memory_stage.sv | 186 ++++++++++++++++++
 tb/tb_memory_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: data-memory load/store stage between execute and writeback.
// Define MEM_MISALIGN_CHECK_EN to add misaligned_out and suppress misaligned requests.
module memory_stage #(
    localparam int ADDR_WIDTH              = 32,
    localparam int DATA_WIDTH              = 32,
    localparam int NUM_REGISTERS           = 32,
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               stall_prev,
    input  logic                               prev_done,
    input  logic                               next_stall,
    output logic                               done_next,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_write,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic [DATA_WIDTH/8-1:0]            mem_wstrb,
    input  logic                               mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    input  logic [ADDR_WIDTH-1:0]              program_count_in,
    output logic [ADDR_WIDTH-1:0]              program_count_out,
    input  logic                               program_count_valid_in,
    output logic                               program_count_valid_out,
    input  logic                               register_arith_in,
    output logic                               register_arith_out,
    input  logic                               immediate_arith_in,
    output logic                               immediate_arith_out,
    input  logic                               load_in,
    output logic                               load_out,
    input  logic                               store_in,
    output logic                               store_out,
    input  logic                               branch_in,
    output logic                               branch_out,
    input  logic                               immediate_jump_in,
    output logic                               immediate_jump_out,
    input  logic                               register_jump_in,
    output logic                               register_jump_out,
    input  logic                               load_upper_in,
    output logic                               load_upper_out,
    input  logic                               load_upper_pc_in,
    output logic                               load_upper_pc_out,
    input  logic                               environment_in,
    output logic                               environment_out,
    input  logic                               opcode_legal_in,
    output logic                               opcode_legal_out,
    input  logic [2:0]                         funct3_in,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
    output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
    input  logic                               write_register_valid_in,
    output logic                               write_register_valid_out,
    input  logic [DATA_WIDTH-1:0]              result_data_in,
    input  logic                               result_data_valid_in,
    output logic                               result_data_valid_out,
    input  logic [DATA_WIDTH-1:0]              store_data_in,
    output logic [DATA_WIDTH-1:0]              result_data_out
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                               misaligned_out
`endif
);

    typedef enum logic [2:0] {EMPTY, REQ, WAIT, HOLD, DONE} state_t;

    state_t                  state, state_nx, accept_state;
    logic                    transfer_prev, transfer_next, is_mem_in, misaligned_in;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [DATA_WIDTH-1:0]   store_data_p1;
    logic [2:0]              funct3_p1;

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] off,
                                                          input logic [2:0] f3);
        logic [DATA_WIDTH-1:0]        lane;
        logic signed [7:0]            lane_b;
        logic signed [15:0]           lane_h;
        logic signed [DATA_WIDTH-1:0] ext;
        lane   = word >> {off, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (f3)
            3'b000:  ext = DATA_WIDTH'(lane_b);
            3'b001:  ext = DATA_WIDTH'(lane_h);
            3'b100:  ext = {24'b0, lane[7:0]};
            3'b101:  ext = {16'b0, lane[15:0]};
            default: ext = lane;
        endcase
        return ext;
    endfunction

    function automatic logic [DATA_WIDTH/8-1:0] store_strobe(input logic [1:0] size,
                                                             input logic [1:0] off);
        logic [DATA_WIDTH/8-1:0] base;
        case (size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    assign is_mem_in     = load_in || store_in;
    assign misaligned_in = (funct3_in[1:0] == 2'b01 && result_data_in[0]) ||
                           (funct3_in[1:0] == 2'b10 && result_data_in[1:0] != 2'b00);
    assign transfer_prev = prev_done && !stall_prev;
    assign transfer_next = done_next && !next_stall;

    // Stage p1 boundary: payload latched on acceptance, load result on response
    always_ff @(posedge clk) begin
        if (transfer_prev) begin
            addr_p1                 <= result_data_in;
            store_data_p1           <= store_data_in;
            funct3_p1               <= funct3_in;
            program_count_out       <= program_count_in;
            program_count_valid_out <= program_count_valid_in;
            register_arith_out      <= register_arith_in;
            immediate_arith_out     <= immediate_arith_in;
            load_out                <= load_in;
            store_out               <= store_in;
            branch_out              <= branch_in;
            immediate_jump_out      <= immediate_jump_in;
            register_jump_out       <= register_jump_in;
            load_upper_out          <= load_upper_in;
            load_upper_pc_out       <= load_upper_pc_in;
            environment_out         <= environment_in;
            opcode_legal_out        <= opcode_legal_in;
            write_register_out      <= write_register_in;
            result_data_valid_out   <= result_data_valid_in;
            result_data_out         <= result_data_in;
`ifdef MEM_MISALIGN_CHECK_EN
            write_register_valid_out <= write_register_valid_in && !(is_mem_in && misaligned_in);
`else
            write_register_valid_out <= write_register_valid_in;
`endif
        end else if (state == WAIT && mem_resp_valid && load_out && !store_out) begin
            result_data_out <= load_extend(mem_rdata, addr_p1[1:0], funct3_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                misaligned_out <= 1'b0;
        else if (transfer_prev) misaligned_out <= is_mem_in && misaligned_in;
    end
`endif

    always_comb begin
        accept_state = HOLD;
        if (is_mem_in) begin
`ifdef MEM_MISALIGN_CHECK_EN
            accept_state = misaligned_in ? DONE : REQ;
`else
            accept_state = REQ;
`endif
        end
        state_nx = state;
        case (state)
            EMPTY:      if (transfer_prev) state_nx = accept_state;
            HOLD, DONE: if (transfer_next) state_nx = transfer_prev ? accept_state : EMPTY;
            REQ:        if (mem_req_ready) state_nx = WAIT;
            WAIT:       if (mem_resp_valid) state_nx = DONE;
            default:    state_nx = EMPTY;
        endcase
    end

    always_comb begin
        done_next     = !rst && (state == HOLD || state == DONE);
        mem_req_valid = !rst && state == REQ;
        stall_prev    = rst || !(state == EMPTY ||
                                 ((state == HOLD || state == DONE) && transfer_next));
    end

    // Request bus driven straight from the p1 payload so it is stable until accepted
    assign mem_addr  = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write = store_out;
    assign mem_wdata = store_data_p1 << {addr_p1[1:0], 3'b000};
    assign mem_wstrb = store_out ? store_strobe(funct3_p1[1:0], addr_p1[1:0]) : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// loads/stores compared against a byte-level arithmetic reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_prev, prev_done, next_stall, done_next;
    logic        mem_req_valid, mem_req_ready, mem_write, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] program_count_in, program_count_out;
    logic        program_count_valid_in, program_count_valid_out;
    logic        register_arith_in, register_arith_out, immediate_arith_in, immediate_arith_out;
    logic        load_in, load_out, store_in, store_out, branch_in, branch_out;
    logic        immediate_jump_in, immediate_jump_out, register_jump_in, register_jump_out;
    logic        load_upper_in, load_upper_out, load_upper_pc_in, load_upper_pc_out;
    logic        environment_in, environment_out, opcode_legal_in, opcode_legal_out;
    logic [2:0]  funct3_in;
    logic [4:0]  write_register_in, write_register_out;
    logic        write_register_valid_in, write_register_valid_out;
    logic [31:0] result_data_in, store_data_in, result_data_out;
    logic        result_data_valid_in, result_data_valid_out;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misaligned_out;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .stall_prev(stall_prev), .prev_done(prev_done),
        .next_stall(next_stall), .done_next(done_next),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .program_count_in(program_count_in), .program_count_out(program_count_out),
        .program_count_valid_in(program_count_valid_in), .program_count_valid_out(program_count_valid_out),
        .register_arith_in(register_arith_in), .register_arith_out(register_arith_out),
        .immediate_arith_in(immediate_arith_in), .immediate_arith_out(immediate_arith_out),
        .load_in(load_in), .load_out(load_out), .store_in(store_in), .store_out(store_out),
        .branch_in(branch_in), .branch_out(branch_out),
        .immediate_jump_in(immediate_jump_in), .immediate_jump_out(immediate_jump_out),
        .register_jump_in(register_jump_in), .register_jump_out(register_jump_out),
        .load_upper_in(load_upper_in), .load_upper_out(load_upper_out),
        .load_upper_pc_in(load_upper_pc_in), .load_upper_pc_out(load_upper_pc_out),
        .environment_in(environment_in), .environment_out(environment_out),
        .opcode_legal_in(opcode_legal_in), .opcode_legal_out(opcode_legal_out),
        .funct3_in(funct3_in),
        .write_register_in(write_register_in), .write_register_out(write_register_out),
        .write_register_valid_in(write_register_valid_in), .write_register_valid_out(write_register_valid_out),
        .result_data_in(result_data_in), .result_data_valid_in(result_data_valid_in),
        .result_data_valid_out(result_data_valid_out), .store_data_in(store_data_in),
        .result_data_out(result_data_out)
`ifdef MEM_MISALIGN_CHECK_EN
        , .misaligned_out(misaligned_out)
`endif
    );

    // Reference model: size in bytes from funct3, then plain arithmetic on byte values.
    function automatic int ref_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        longint v;
        int     n;
        n = ref_size(f3);
        v = (longint'(word) >> (8 * (addr % 4))) % (longint'(1) << (8 * n));
        if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_strobe(input logic [31:0] addr, input logic [2:0] f3);
        logic [3:0] s;
        s = 4'b0;
        for (int i = 0; i < ref_size(f3); i++)
            if (addr % 4 + i < 4) s[addr % 4 + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prev_done = 0; next_stall = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = $urandom;
        load_in = 0; store_in = 0; funct3_in = 3'b010;
        register_arith_in = 0; immediate_arith_in = 0; branch_in = 0; immediate_jump_in = 0;
        register_jump_in = 0; load_upper_in = 0; load_upper_pc_in = 0; environment_in = 0;
        opcode_legal_in = 0; program_count_in = 0; program_count_valid_in = 0;
        write_register_in = 0; write_register_valid_in = 0; result_data_in = 0;
        result_data_valid_in = 0; store_data_in = 0;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] res, input logic [31:0] sd);
        prev_done = 1; load_in = ld; store_in = st; funct3_in = f3;
        result_data_in = res; store_data_in = sd;
        register_arith_in = !(ld || st); opcode_legal_in = 1;
        program_count_in = $urandom; program_count_valid_in = 1;
        write_register_in = 5'($urandom); write_register_valid_in = 1; result_data_valid_in = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        present(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        repeat (3) begin
            tick();
            vectors++;
            if (stall_prev !== 1'b1 || done_next !== 1'b0 || mem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs: stall_prev=%b done_next=%b req=%b, required 1 0 0",
                         stall_prev, done_next, mem_req_valid);
            end
        end
        idle_inputs();
        rst = 0;
        tick();
        vectors++;
        if (stall_prev !== 1'b0 || done_next !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: stall_prev=%b done_next=%b req=%b, required 0 0 0",
                     stall_prev, done_next, mem_req_valid);
        end
    endtask

    task automatic test_alu();
        logic [31:0] pc;
        logic [4:0]  rd;
        present(1'b0, 1'b0, 3'b000, 32'h1234, 32'hDEAD);
        branch_in = 1; environment_in = 1;
        pc = program_count_in; rd = write_register_in;
        tick();
        idle_inputs();
        vectors++;
        if (done_next !== 1'b1 || result_data_out !== 32'h1234 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_result: done=%b result=%h req=%b, required 1 00001234 0",
                     done_next, result_data_out, mem_req_valid);
        end
        vectors++;
        if (program_count_out !== pc || write_register_out !== rd || branch_out !== 1'b1 ||
            environment_out !== 1'b1 || register_arith_out !== 1'b1 || load_upper_out !== 1'b0 ||
            write_register_valid_out !== 1'b1 || result_data_valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_passthrough: pc=%h rd=%0d br=%b env=%b, required pc=%h rd=%0d br=1 env=1",
                     program_count_out, write_register_out, branch_out, environment_out, pc, rd);
        end
        tick();
        vectors++;
        if (done_next !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_drain: done=%b req=%b, required 0 0", done_next, mem_req_valid);
        end
    endtask

    task automatic test_load_directed();
        logic [2:0]  f3s [2] = '{3'b000, 3'b100};
        logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
        for (int k = 0; k < 2; k++) begin
            present(1'b1, 1'b0, f3s[k], 32'h103, 32'h0);
            tick();
            idle_inputs();
            vectors++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100 || mem_write !== 1'b0 || mem_wstrb !== 4'b0) begin
                miscompares++;
                $display("FAIL load_request: req=%b addr=%h write=%b strb=%b, required 1 00000100 0 0000",
                         mem_req_valid, mem_addr, mem_write, mem_wstrb);
            end
            mem_req_ready = 1;
            tick();
            mem_req_ready = 0;
            mem_resp_valid = 1; mem_rdata = 32'h80AABBCC;
            tick();
            mem_resp_valid = 0; mem_rdata = $urandom;
            vectors++;
            if (done_next !== 1'b1 || result_data_out !== exp[k]) begin
                miscompares++;
                $display("FAIL load_extend: done=%b result=%h, required 1 %h", done_next, result_data_out, exp[k]);
            end
            tick();
        end
    endtask

    task automatic test_store_stall();
        present(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1;
            vectors++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h200 || mem_write !== 1'b1 ||
                mem_wstrb !== 4'b1100 || mem_wdata !== 32'hBEEF0000 || done_next !== 1'b0) begin
                miscompares++;
                $display("FAIL store_request_cycle%0d: req=%b addr=%h wr=%b strb=%b wdata=%h done=%b, required 1 00000200 1 1100 beef0000 0",
                         i, mem_req_valid, mem_addr, mem_write, mem_wstrb, mem_wdata, done_next);
            end
            tick();
        end
        mem_req_ready = 0;
        vectors++;
        if (mem_req_valid !== 1'b0 || done_next !== 1'b0) begin
            miscompares++;
            $display("FAIL store_wait: req=%b done=%b, required 0 0", mem_req_valid, done_next);
        end
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        vectors++;
        if (done_next !== 1'b1 || result_data_out !== 32'h202) begin
            miscompares++;
            $display("FAIL store_done: done=%b result=%h, required 1 00000202", done_next, result_data_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] last, v;
        last = 0;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            present(1'b0, 1'b0, 3'b000, v, 32'h0);
            #1;
            vectors++;
            if (stall_prev !== 1'b0 || (i > 0 && (done_next !== 1'b1 || result_data_out !== last))) begin
                miscompares++;
                $display("FAIL b2b_op%0d: stall=%b done=%b result=%h, required 0 1 %h",
                         i, stall_prev, done_next, result_data_out, last);
            end
            last = v;
            tick();
        end
        next_stall = 1;
        v = $urandom;
        present(1'b0, 1'b0, 3'b000, v, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (stall_prev !== 1'b1 || done_next !== 1'b1 || result_data_out !== last) begin
                miscompares++;
                $display("FAIL b2b_hold%0d: stall=%b done=%b result=%h, required 1 1 %h",
                         i, stall_prev, done_next, result_data_out, last);
            end
            tick();
        end
        next_stall = 0;
        #1;
        vectors++;
        if (stall_prev !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_release: stall=%b, required 0", stall_prev);
        end
        tick();
        idle_inputs();
        vectors++;
        if (done_next !== 1'b1 || result_data_out !== v) begin
            miscompares++;
            $display("FAIL b2b_resume: done=%b result=%h, required 1 %h", done_next, result_data_out, v);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        present(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        tick();
        idle_inputs();
        rst = 1;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0 || stall_prev !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_req: req=%b stall=%b, required 0 1", mem_req_valid, stall_prev);
        end
        tick();
        rst = 0;
        present(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
        tick();
        idle_inputs();
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        mem_resp_valid = 1; mem_rdata = 32'h12345678;
        tick();
        mem_resp_valid = 0;
        tick();
        vectors++;
        if (done_next !== 1'b0 || stall_prev !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_wait: done=%b stall=%b req=%b, required 0 0 0",
                     done_next, stall_prev, mem_req_valid);
        end
    endtask

    task automatic test_random_mem();
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic        st;
        logic [31:0] addr, sd, word, res, strb_m;
        logic [3:0]  strb;
        for (int n = 0; n < 40; n++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            addr = $urandom & ~32'(ref_size(f3) - 1);
            sd   = $urandom;
            word = $urandom;
            present(!st || $urandom_range(0, 1) == 1, st, f3, addr, sd);
            tick();
            idle_inputs();
            strb   = st ? ref_strobe(addr, f3) : 4'b0;
            strb_m = ref_lane_mask(strb);
            for (int d = $urandom_range(0, 3); d >= 0; d--) begin
                if (d == 0) mem_req_ready = 1;
                vectors++;
                if (mem_req_valid !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || mem_write !== st ||
                    mem_wstrb !== strb || (mem_wdata & strb_m) !== ((sd << (8 * (addr % 4))) & strb_m)) begin
                    miscompares++;
                    $display("FAIL rand_req%0d: req=%b addr=%h wr=%b strb=%b wdata=%h, required 1 %h %b %b lanes of %h",
                             n, mem_req_valid, mem_addr, mem_write, mem_wstrb, mem_wdata,
                             {addr[31:2], 2'b00}, st, strb, sd << (8 * (addr % 4)));
                end
                tick();
            end
            mem_req_ready = 0;
            repeat ($urandom_range(0, 2)) tick();
            mem_resp_valid = 1; mem_rdata = word;
            tick();
            mem_resp_valid = 0; mem_rdata = $urandom;
            res = st ? addr : ref_load(word, addr, f3);
            vectors++;
            if (done_next !== 1'b1 || result_data_out !== res) begin
                miscompares++;
                $display("FAIL rand_result%0d: done=%b result=%h, required 1 %h", n, done_next, result_data_out, res);
            end
            tick();
        end
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misaligned();
        present(1'b1, 1'b0, 3'b010, 32'h301, 32'h0);
        tick();
        idle_inputs();
        vectors++;
        if (mem_req_valid !== 1'b0 || done_next !== 1'b1 || misaligned_out !== 1'b1 ||
            write_register_valid_out !== 1'b0 || result_data_out !== 32'h301) begin
            miscompares++;
            $display("FAIL misaligned_lw: req=%b done=%b mis=%b wrv=%b result=%h, required 0 1 1 0 00000301",
                     mem_req_valid, done_next, misaligned_out, write_register_valid_out, result_data_out);
        end
        tick();
        present(1'b0, 1'b0, 3'b010, 32'h301, 32'h0);
        tick();
        idle_inputs();
        vectors++;
        if (misaligned_out !== 1'b0 || write_register_valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL misaligned_clear: mis=%b wrv=%b, required 0 1", misaligned_out, write_register_valid_out);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load_directed();
        test_store_stall();
        test_back_to_back();
        test_reset_mid();
        test_random_mem();
`ifdef MEM_MISALIGN_CHECK_EN
        test_misaligned();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
